// File: rtl/im_loader.sv
// im_loader: loads a framed byte stream of 15-bit words into instruction memory,
// holding the CPU until a complete frame with a matching checksum has arrived.
module im_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [INSTR_W-1:0] im_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {IDLE, COUNT, HI, LO, WRITE, CSUM, DONE, ERR} state_t;

    state_t            state, state_nx;
    logic [ADDR_W:0]   n_words, n_lim;
    logic [8:0]        n_raw;
    logic [6:0]        hi;
    logic [7:0]        csum;
    logic              last, idle;

    // a COUNT of zero stands for 256 words, never more than the memory holds
    assign n_raw    = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
    assign n_lim    = (32'(n_raw) > 32'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'(n_raw);
    assign last     = (word_count + (ADDR_W+1)'(1)) == n_words;
    assign idle     = (state == IDLE) || (state == DONE) || (state == ERR);
    assign cpu_hold = (state != IDLE) && (state != DONE);
    assign done     = state == DONE;
    assign error    = state == ERR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        im_we    = 1'b0;
        case (state)
            IDLE, DONE, ERR: state_nx = start ? COUNT : state;
            COUNT: begin
                in_ready = 1'b1;
                state_nx = in_valid ? HI : COUNT;
            end
            HI: begin
                in_ready = 1'b1;
                state_nx = !in_valid ? HI : (in_data[7] ? ERR : LO);
            end
            LO: begin
                in_ready = 1'b1;
                state_nx = in_valid ? WRITE : LO;
            end
            WRITE: begin
                im_we    = 1'b1;
                state_nx = last ? CSUM : HI;
            end
            CSUM: begin
                in_ready = 1'b1;
                state_nx = !in_valid ? CSUM : ((in_data == csum) ? DONE : ERR);
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_words    <= '0;
            hi         <= '0;
            csum       <= '0;
            im_addr    <= '0;
            im_wdata   <= '0;
            word_count <= '0;
        end else if (idle) begin
            if (start) begin
                csum       <= '0;
                im_addr    <= '0;
                word_count <= '0;
            end
        end else if (state == COUNT) begin
            if (in_valid) begin
                n_words <= n_lim;
                csum    <= csum + in_data;
            end
        end else if (state == HI) begin
            if (in_valid && !in_data[7]) begin
                hi   <= in_data[6:0];
                csum <= csum + in_data;
            end
        end else if (state == LO) begin
            if (in_valid) begin
                im_wdata <= INSTR_W'({hi, in_data});
                csum     <= csum + in_data;
            end
        end else if (state == WRITE) begin
            im_addr    <= im_addr + 1'b1;
            word_count <= word_count + (ADDR_W+1)'(1);
        end
    end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: randomized frame stimulus against a byte-level frame model;
// expected IM writes go through a scoreboard queue checked by a write monitor.
module tb_im_loader;
    localparam int AW = 8;
    typedef logic [7:0] byte_t;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_ready, im_we, cpu_hold, done, error;
    logic [AW-1:0] im_addr;
    logic [14:0]   im_wdata;
    logic [AW:0]   word_count;

    int          vectors = 0, miscompares = 0;
    bit          gaps = 1'b0;
    logic [22:0] exp_q[$];
    logic [22:0] exp_w;
    byte_t       frame[$];
    byte_t       nominal[$] = '{8'h02, 8'h01, 8'h63, 8'h7F, 8'hFF, 8'hE4};

    im_loader #(.ADDR_W(AW), .INSTR_W(15)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && im_we) begin
            check("in_ready_in_write", 32'(in_ready), 0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: addr %0h data %0h, no write expected", im_addr, im_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                check("write_addr", 32'(im_addr), 32'(exp_w[22:15]));
                check("write_data", 32'(im_wdata), 32'(exp_w[14:0]));
            end
        end
    end

    // parses a frame the way the loader should, queuing the writes it must make
    task automatic model(input byte_t f[$], output bit ok, output bit err, output int wc);
        int    n, i;
        byte_t sum;
        n   = (f[0] == 0) ? 256 : int'(f[0]);
        n   = (n > (1 << AW)) ? (1 << AW) : n;
        sum = f[0];
        i   = 1;
        wc  = 0;
        ok  = 1'b0;
        err = 1'b0;
        for (int w = 0; w < n; w++) begin
            if (f[i][7]) begin
                err = 1'b1;
                return;
            end
            exp_q.push_back({8'(w), f[i][6:0], f[i+1]});
            sum = sum + f[i] + f[i+1];
            i += 2;
            wc++;
        end
        ok  = (f[i] == sum);
        err = !ok;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input byte_t b);
        int t = 0;
        bit hs;
        if (gaps) repeat ($urandom_range(0, 3)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        do begin
            hs = in_ready;
            @(posedge clk); #1;
            t++;
        end while (!hs && t < 100);
        if (!hs) check("handshake_timeout", 0, 1);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic run_frame(input byte_t f[$], input int poke);
        bit ok, err;
        int wc;
        model(f, ok, err, wc);
        pulse_start();
        check("hold_after_start", 32'(cpu_hold), 1);
        check("done_cleared", 32'(done), 0);
        foreach (f[k]) begin
            if (k == poke) begin
                pulse_start();
                check("hold_busy_start", 32'(cpu_hold), 1);
            end
            send_byte(f[k]);
        end
        repeat (2) begin @(posedge clk); #1; end
        check("done", 32'(done), 32'(ok));
        check("error", 32'(error), 32'(err));
        check("cpu_hold", 32'(cpu_hold), 32'(!ok));
        check("word_count", 32'(word_count), 32'(wc));
        check("writes_pending", 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_im_we"}, 32'(im_we), 0);
        check({tag, "_im_addr"}, 32'(im_addr), 0);
        check({tag, "_im_wdata"}, 32'(im_wdata), 0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_word_count"}, 32'(word_count), 0);
    endtask

    initial begin
        bit ok, err;
        int wc, n;
        byte_t sum;
        logic [14:0] w;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_frame(nominal, -1);
        frame = nominal;
        frame[5] = 8'hE5;
        run_frame(frame, -1);
        frame = '{8'h01, 8'h80};
        run_frame(frame, -1);
        gaps = 1'b1;
        run_frame(nominal, -1);
        gaps = 1'b0;

        model(nominal, ok, err, wc);
        pulse_start();
        for (int k = 0; k < 3; k++) send_byte(nominal[k]);
        @(negedge clk); #1;
        check("first_write_seen", 32'(exp_q.size()), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midload_reset");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_frame(nominal, -1);

        run_frame(nominal, 1);
        frame = '{8'h01, 8'h12, 8'h34, 8'h47};
        run_frame(frame, -1);

        for (int r = 0; r < 8; r++) begin
            gaps = 1'($urandom);
            n    = (r == 7) ? 256 : int'($urandom_range(1, 6));
            frame.delete();
            frame.push_back(8'(n));
            sum = 8'(n);
            for (int i = 0; i < n; i++) begin
                w = 15'($urandom);
                frame.push_back({1'b0, w[14:8]});
                frame.push_back(w[7:0]);
                sum = sum + {1'b0, w[14:8]} + w[7:0];
            end
            frame.push_back(($urandom_range(0, 3) == 0) ? sum + 8'd1 : sum);
            run_frame(frame, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
